// File: rtl/seq_divider16_pkg.sv
// ---------------------------------------------------------------------------
// seq_divider16_pkg
//   Shared ALU definitions for the sequential restoring divider.
//   - DIV_WIDTH   : default operand/quotient/remainder width
//   - DIV_CW      : default iteration counter width (2^DIV_CW > DIV_WIDTH)
//   - div_state_t : divider control state encoding
//   - DZ_QUOTIENT : quotient reported on divide-by-zero (all ones)
// ---------------------------------------------------------------------------
package seq_divider16_pkg;

   localparam int DIV_WIDTH = 16;
   localparam int DIV_CW    = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } div_state_t;

   localparam logic [DIV_WIDTH-1:0] DZ_QUOTIENT = '1;

endpackage

// File: rtl/borrow_sub17.sv
// ---------------------------------------------------------------------------
// borrow_sub17
//   Combinational N-bit ripple-borrow subtractor, one full-subtractor per bit,
//   mirroring the full-adder chain of the adder datapath.
//   Ports:
//     minuend    in  N  left operand
//     subtrahend in  N  right operand
//     diff       out N  minuend - subtrahend (mod 2^N)
//     borrow_out out 1  set when subtrahend > minuend
// ---------------------------------------------------------------------------
module borrow_sub17 #(
   parameter int N = 17
) (
   input  logic [N-1:0] minuend,
   input  logic [N-1:0] subtrahend,
   output logic [N-1:0] diff,
   output logic         borrow_out
);

   logic [N:0] borrow;

   assign borrow[0] = 1'b0;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_stage
         assign diff[gi]     = minuend[gi] ^ subtrahend[gi] ^ borrow[gi];
         // Borrow out of a stage: subtrahend bit exceeds minuend bit, or they
         // are equal and a borrow came in from below.
         assign borrow[gi+1] = (~minuend[gi] & subtrahend[gi])
                             | (~(minuend[gi] ^ subtrahend[gi]) & borrow[gi]);
      end
   endgenerate

   assign borrow_out = borrow[N];

endmodule

// File: rtl/seq_divider16.sv
// ---------------------------------------------------------------------------
// seq_divider16
//   Multi-cycle unsigned restoring divider, one quotient bit per clock,
//   MSB first. Divide-by-zero is detected at start and answered in one step.
//   Ports:
//     clk         in  1      rising-edge clock
//     rst         in  1      synchronous active-high reset
//     start       in  1      request, sampled only while busy=0
//     dividend    in  WIDTH  numerator, latched at accepted start
//     divisor     in  WIDTH  denominator, latched at accepted start
//     busy        out 1      operation in progress
//     done        out 1      one-cycle pulse when results update
//     quotient    out WIDTH  result quotient (held)
//     remainder   out WIDTH  result remainder (held)
//     div_by_zero out 1      latched divisor was zero (held)
// ---------------------------------------------------------------------------
module seq_divider16
   import seq_divider16_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH,
   parameter int CW    = DIV_CW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   div_state_t       state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] rem_q;      // partial remainder (see note on width below)
   logic [WIDTH-1:0] quo_q;      // shifting dividend / quotient register
   logic [WIDTH-1:0] div_q;      // latched divisor
   logic             dz_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;
   logic             div_by_zero_q;

   // Trial subtraction of the divisor from the shifted partial remainder.
   logic [WIDTH:0]   trial_a;
   logic [WIDTH:0]   trial_diff;
   logic             trial_borrow;
   logic             trial_msb_unused;

   assign trial_a = {rem_q, quo_q[WIDTH-1]};

   borrow_sub17 #(
      .N (WIDTH + 1)
   ) u_sub (
      .minuend    (trial_a),
      .subtrahend ({1'b0, div_q}),
      .diff       (trial_diff),
      .borrow_out (trial_borrow)
   );

   // The partial remainder is always below the divisor, so the next partial
   // remainder (whether restored or subtracted) fits in WIDTH bits and its
   // top bit is always zero; only WIDTH bits are stored.
   assign trial_msb_unused = trial_diff[WIDTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         rem_q         <= '0;
         quo_q         <= '0;
         div_q         <= '0;
         dz_q          <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         quotient_q    <= '0;
         remainder_q   <= '0;
         div_by_zero_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  div_q  <= divisor;
                  quo_q  <= dividend;
                  rem_q  <= '0;
                  busy_q <= 1'b1;
                  if (divisor == '0) begin
                     dz_q    <= 1'b1;
                     state_q <= FINISH;
                  end else begin
                     dz_q    <= 1'b0;
                     cnt_q   <= CW'(WIDTH);
                     state_q <= RUN;
                  end
               end
            end
            RUN: begin
               if (!trial_borrow) begin
                  rem_q <= trial_diff[WIDTH-1:0];
                  quo_q <= {quo_q[WIDTH-2:0], 1'b1};
               end else begin
                  rem_q <= trial_a[WIDTH-1:0];
                  quo_q <= {quo_q[WIDTH-2:0], 1'b0};
               end
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CW'(1)) begin
                  state_q <= FINISH;
               end
            end
            FINISH: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
               if (dz_q) begin
                  // quo_q still holds the untouched latched dividend.
                  quotient_q    <= DZ_QUOTIENT;
                  remainder_q   <= quo_q;
                  div_by_zero_q <= 1'b1;
               end else begin
                  quotient_q    <= quo_q;
                  remainder_q   <= rem_q;
                  div_by_zero_q <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_seq_divider16.sv
// ---------------------------------------------------------------------------
// tb_seq_divider16
//   Scoreboard bench for seq_divider16: stimulus pushes the expected result
//   and completion cycle, a monitor pops and compares on every done pulse.
// ---------------------------------------------------------------------------
module tb_seq_divider16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] dividend = '0;
   logic [15:0] divisor = '0;
   logic        busy;
   logic        done;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        div_by_zero;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      logic [15:0] q;
      logic [15:0] r;
      logic        dz;
      int          cyc;
   } exp_t;

   exp_t sb[$];

   seq_divider16 dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse is matched against the oldest expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            $display("done @%0d: q=%h r=%h dz=%b (expected q=%h r=%h dz=%b @%0d)",
                     cyc, quotient, remainder, div_by_zero, e.q, e.r, e.dz, e.cyc);
            chk("quotient",    32'(quotient),    32'(e.q));
            chk("remainder",   32'(remainder),   32'(e.r));
            chk("div_by_zero", 32'(div_by_zero), 32'(e.dz));
            chk("done_cycle",  32'(cyc),         32'(e.cyc));
            chk("busy_in_done", 32'(busy),       32'd0);
         end
      end
   end

   // Called at a negedge; start is sampled at the next posedge (edge E).
   // done must be visible after edge E+17 (E+1 for divide-by-zero).
   task automatic issue(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eq, input logic [15:0] er, input logic edz);
      exp_t e;
      e.q   = eq;
      e.r   = er;
      e.dz  = edz;
      e.cyc = cyc + 1 + (edz ? 1 : 17);
      sb.push_back(e);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      dividend = 16'hDEAD;   // inputs are don't-care after acceptance
      divisor  = 16'h0000;
   endtask

   // Returns at the negedge of the done cycle, bounded.
   task automatic wait_done(input string name);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!done && k < 40);
      chk(name, 32'(done), 32'd1);
   endtask

   initial begin
      int unsigned a, b;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_q",    32'(quotient), 32'd0);
      chk("rst_r",    32'(remainder), 32'd0);
      chk("rst_dz",   32'(div_by_zero), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // 100 / 7 = 14 r 2
      issue(16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
      chk("busy_after_start", 32'(busy), 32'd1);
      wait_done("wait_100_7");

      // Boundary operands
      issue(16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0);
      wait_done("wait_ffff_1");
      issue(16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0);
      wait_done("wait_ffff_ffff");
      issue(16'd3, 16'd10, 16'd0, 16'd3, 1'b0);
      wait_done("wait_3_10");

      // Divide by zero, then a normal divide clears the flag
      issue(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1);
      wait_done("wait_5_0");
      issue(16'd9, 16'd3, 16'd3, 16'd0, 1'b0);
      wait_done("wait_9_3");

      // Start while busy is ignored; start in the done cycle is accepted
      issue(16'd1000, 16'd10, 16'd100, 16'd0, 1'b0);
      repeat (3) @(negedge clk);
      dividend = 16'd7;
      divisor  = 16'd7;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      wait_done("wait_1000_10");
      issue(16'd7, 16'd7, 16'd1, 16'd0, 1'b0);
      wait_done("wait_7_7");

      // Reset in the middle of a division: abandoned, no done afterwards
      issue(16'd50000, 16'd123, 16'd406, 16'd62, 1'b0);
      repeat (7) @(negedge clk);
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_q",    32'(quotient), 32'd0);
      chk("midrst_r",    32'(remainder), 32'd0);
      chk("midrst_dz",   32'(div_by_zero), 32'd0);
      rst = 1'b0;
      repeat (25) @(negedge clk);
      chk("midrst_idle", 32'(busy), 32'd0);
      issue(16'd50000, 16'd123, 16'd406, 16'd62, 1'b0);
      wait_done("wait_50000_123");

      // Random sweep, issued back to back in each done cycle
      for (int i = 0; i < 1000; i++) begin
         a = $urandom_range(0, 65535);
         b = (i % 2 == 0) ? $urandom_range(1, 255) : $urandom_range(1, 65535);
         issue(16'(a), 16'(b), 16'(a / b), 16'(a % b), 1'b0);
         wait_done("wait_random");
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

endmodule
